// File: rtl/mem_stage_ctrl_pkg.sv
// rtl/mem_stage_ctrl_pkg.sv - shared constants, FSM encoding and MEM/WB entry type
package mem_stage_ctrl_pkg;

  localparam int MEM_R_BIT  = 1;
  localparam int MEM_W_BIT  = 0;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     alu_result;
    logic [DATA_W-1:0]     mem_data;
  } memwb_t;

  // MEM_Signal = 2'b11 is treated as a read, so only a pure write-enable stores.
  function automatic logic is_store(input logic [1:0] mem_signal);
    return mem_signal[MEM_W_BIT] && !mem_signal[MEM_R_BIT];
  endfunction

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - word-memory req/ready handshake between the memory stage and memory
interface mem_stage_ctrl_if #(
  parameter int ADDR_W = 16
) ();
  import mem_stage_ctrl_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ready
  );

endinterface

// File: rtl/mem_stage_ctrl_memwb.sv
// rtl/mem_stage_ctrl_memwb.sv - MEM/WB pipeline register, loads a bubble while frozen
module mem_stage_ctrl_memwb
  import mem_stage_ctrl_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   freeze_i,
  input  memwb_t entry_i,
  output memwb_t entry_o
);

  memwb_t entry_q;
  memwb_t entry_d;

  always_comb begin
    entry_d = entry_i;
    if (freeze_i) begin
      entry_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  assign entry_o = entry_q;

endmodule

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory stage: load/store handshake, upstream freeze, timeout abort, MEM/WB feed
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  WB_en_in,
  input  logic [1:0]            MEM_Signal_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic [DATA_W-1:0]     PC_in,
  input  logic [DATA_W-1:0]     ALU_result_in,
  input  logic [DATA_W-1:0]     reg2_in,

  mem_stage_ctrl_if.master      mem,

  output logic                  freeze,
  output logic                  mem_err,

  output logic                  WB_en_out,
  output logic                  MEM_R_en_out,
  output logic [REG_ADDR_W-1:0] dest_out,
  output logic [DATA_W-1:0]     PC_out,
  output logic [DATA_W-1:0]     ALU_result_out,
  output logic [DATA_W-1:0]     mem_data_out
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic              acc;
  logic              in_wait;
  logic              done_ok;
  logic              timeout_hit;
  logic              rd_done;
  memwb_t            wb_entry;
  memwb_t            wb_q;

  assign acc     = |MEM_Signal_in;
  assign in_wait = (state_q == WAIT);
  assign done_ok = in_wait && mem.mem_ready;
  assign rd_done = done_ok && !we_q;

  // mem_ready wins over an expiring counter in the same cycle.
  generate
    if (TIMEOUT != 0) begin : g_timeout
      assign timeout_hit = in_wait && !mem.mem_ready && (cnt_q == CNT_W'(TIMEOUT - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (acc) begin
          state_d = WAIT;
          we_d    = is_store(MEM_Signal_in);
          addr_d  = ALU_result_in[ADDR_W+1:2];
          wdata_d = reg2_in;
        end
      end
      WAIT: begin
        if (done_ok || timeout_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = timeout_hit;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign mem.mem_req   = in_wait;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  // Upstream is released on the completing (or aborting) cycle so EXE/MEM advances with it.
  assign freeze  = acc && !(done_ok || timeout_hit);
  assign mem_err = err_q;

  always_comb begin
    wb_entry            = '0;
    wb_entry.wb_en      = WB_en_in;
    wb_entry.mem_r_en   = MEM_Signal_in[MEM_R_BIT];
    wb_entry.dest       = dest_in;
    wb_entry.pc         = PC_in;
    wb_entry.alu_result = ALU_result_in;
    wb_entry.mem_data   = rd_done ? mem.mem_rdata : '0;
  end

  mem_stage_ctrl_memwb u_memwb (
    .clk      (clk),
    .rst      (rst),
    .freeze_i (freeze),
    .entry_i  (wb_entry),
    .entry_o  (wb_q)
  );

  assign WB_en_out      = wb_q.wb_en;
  assign MEM_R_en_out   = wb_q.mem_r_en;
  assign dest_out       = wb_q.dest;
  assign PC_out         = wb_q.pc;
  assign ALU_result_out = wb_q.alu_result;
  assign mem_data_out   = wb_q.mem_data;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl with a reference model
module tb_mem_stage_ctrl;

  localparam int AW   = 16;
  localparam int TOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_en_in;
  logic [1:0]  MEM_Signal_in;
  logic [4:0]  dest_in;
  logic [31:0] PC_in, ALU_result_in, reg2_in;
  logic        freeze, mem_err;
  logic        WB_en_out, MEM_R_en_out;
  logic [4:0]  dest_out;
  logic [31:0] PC_out, ALU_result_out, mem_data_out;

  int checks = 0;
  int errors = 0;

  mem_stage_ctrl_if #(.ADDR_W(AW)) mif ();

  mem_stage_ctrl #(.ADDR_W(AW), .TIMEOUT(TOUT)) dut (
    .clk            (clk),
    .rst            (rst),
    .WB_en_in       (WB_en_in),
    .MEM_Signal_in  (MEM_Signal_in),
    .dest_in        (dest_in),
    .PC_in          (PC_in),
    .ALU_result_in  (ALU_result_in),
    .reg2_in        (reg2_in),
    .mem            (mif),
    .freeze         (freeze),
    .mem_err        (mem_err),
    .WB_en_out      (WB_en_out),
    .MEM_R_en_out   (MEM_R_en_out),
    .dest_out       (dest_out),
    .PC_out         (PC_out),
    .ALU_result_out (ALU_result_out),
    .mem_data_out   (mem_data_out)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_memwb_zero(input string tag);
    chk({tag, "_wb"},   WB_en_out, 0);
    chk({tag, "_mr"},   MEM_R_en_out, 0);
    chk({tag, "_dest"}, dest_out, 0);
    chk({tag, "_pc"},   PC_out, 0);
    chk({tag, "_alu"},  ALU_result_out, 0);
    chk({tag, "_data"}, mem_data_out, 0);
  endtask

  // Reference: an access occupies the stage for 'delay' cycles (ready on the delay-th
  // request cycle) or TOUT cycles on timeout (delay = 0); non-memory ops take none.
  task automatic run_instr(input logic wb, input logic [1:0] sig, input logic [4:0] dst,
                           input logic [31:0] pc, input logic [31:0] alu,
                           input logic [31:0] r2, input logic [31:0] rd, input int delay);
    bit          acc;
    bit          tmo;
    int          nfrz;
    logic [31:0] exp_data;
    acc      = (sig != 2'b00);
    tmo      = acc && (delay == 0);
    nfrz     = !acc ? 0 : (tmo ? TOUT : delay);
    exp_data = (acc && sig[1] && !tmo) ? rd : 32'h0;

    WB_en_in      = wb;
    MEM_Signal_in = sig;
    dest_in       = dst;
    PC_in         = pc;
    ALU_result_in = alu;
    reg2_in       = r2;

    for (int c = 0; c <= nfrz; c++) begin
      if (c == 0) begin
        chk("req_idle", mif.mem_req, 0);
        mif.mem_ready = 1'($urandom);
        mif.mem_rdata = $urandom;
      end else begin
        chk("req_wait", mif.mem_req, 1);
        chk("we",       mif.mem_we, (sig == 2'b01));
        chk("addr",     mif.mem_addr, (alu / 4) % (1 << AW));
        chk("wdata",    mif.mem_wdata, r2);
        mif.mem_ready = (!tmo && c == delay);
        mif.mem_rdata = mif.mem_ready ? rd : $urandom;
      end
      #1;
      chk("freeze", freeze, (c < nfrz));
      @(negedge clk);
      if (c < nfrz) begin
        chk("err_low", mem_err, 0);
        chk_memwb_zero("bubble");
      end
    end
    mif.mem_ready = 1'b0;

    chk("wb_out",  WB_en_out, wb);
    chk("mr_out",  MEM_R_en_out, sig[1]);
    chk("dest",    dest_out, dst);
    chk("pc",      PC_out, pc);
    chk("alu",     ALU_result_out, alu);
    chk("data",    mem_data_out, exp_data);
    chk("err",     mem_err, tmo);
    chk("req_end", mif.mem_req, 0);
  endtask

  initial begin
    rst           = 1'b1;
    WB_en_in      = 1'b0;
    MEM_Signal_in = 2'b00;
    dest_in       = '0;
    PC_in         = '0;
    ALU_result_in = '0;
    reg2_in       = '0;
    mif.mem_ready = 1'b0;
    mif.mem_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_we", mif.mem_we, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_wdata", mif.mem_wdata, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_err", mem_err, 0);
    chk_memwb_zero("rst");
    rst = 1'b0;

    // Reset in the middle of an outstanding load, then a stray late mem_ready.
    MEM_Signal_in = 2'b10;
    ALU_result_in = 32'h100;
    WB_en_in      = 1'b1;
    dest_in       = 5'd3;
    @(negedge clk);
    chk("mid_req1", mif.mem_req, 1);
    @(negedge clk);
    chk("mid_req2", mif.mem_req, 1);
    rst           = 1'b1;
    MEM_Signal_in = 2'b00;
    WB_en_in      = 1'b0;
    dest_in       = '0;
    ALU_result_in = '0;
    @(negedge clk);
    chk("mid_rst_req", mif.mem_req, 0);
    chk("mid_rst_freeze", freeze, 0);
    chk_memwb_zero("mid_rst");
    @(negedge clk);
    rst           = 1'b0;
    mif.mem_ready = 1'b1;
    mif.mem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    mif.mem_ready = 1'b0;
    chk("late_rdy_req", mif.mem_req, 0);
    chk("late_rdy_err", mem_err, 0);
    chk_memwb_zero("late_rdy");

    // ALU passthrough
    run_instr(1'b1, 2'b00, 5'd5, 32'h0000_1000, 32'h0000_002A, 32'h0, 32'h0, 1);
    // Load, ready on third request cycle
    run_instr(1'b1, 2'b10, 5'd7, 32'h0000_1004, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 3);
    // Store, immediate ready
    run_instr(1'b0, 2'b01, 5'd0, 32'h0000_1008, 32'h0000_0008, 32'h1234, 32'h0, 1);
    // Load that times out
    run_instr(1'b1, 2'b10, 5'd9, 32'h0000_100C, 32'h0000_0080, 32'h0, 32'h5555_AAAA, 0);
    // Back-to-back load then store, each ready on first request cycle
    run_instr(1'b1, 2'b10, 5'd11, 32'h0000_1010, 32'h0000_0204, 32'h0, 32'h0BAD_F00D, 1);
    run_instr(1'b0, 2'b01, 5'd0,  32'h0000_1014, 32'h0003_FFFC, 32'hA5A5_5A5A, 32'h0, 1);
    // MEM_Signal = 2'b11 behaves as a read
    run_instr(1'b1, 2'b11, 5'd13, 32'h0000_1018, 32'h0000_0010, 32'h77, 32'h1357_9BDF, 2);
    // Ready coinciding with the last counter value still completes normally
    run_instr(1'b1, 2'b10, 5'd14, 32'h0000_101C, 32'h0000_0020, 32'h0, 32'h2468_ACE0, TOUT);

    for (int i = 0; i < 40; i++) begin
      run_instr(1'($urandom), 2'($urandom_range(0, 3)), 5'($urandom), $urandom,
                $urandom, $urandom, $urandom, $urandom_range(0, TOUT));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
- Memory stage that consumes the EXE/MEM pipeline register outputs: WB enable, 2-bit MEM signal, destination, PC, ALU result and reg2.
- Performs loads and stores against an external word memory through a req/ready handshake. Freezes upstream stages while an access is outstanding.
- Drives the MEM/WB register feeding write-back.

Parameters:
ADDR_W, 16, word-address width driven to memory (byte address bits [ADDR_W+1:2])
TIMEOUT, 64, max cycles waiting for mem_ready before abort; 0 disables the timeout

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
WB_en_in  input  1  write-back enable from EXE/MEM
MEM_Signal_in  input  2  bit1 = read enable (load), bit0 = write enable (store)
dest_in  input  5  destination register
PC_in  input  32  PC of instruction
ALU_result_in  input  32  byte address for loads/stores, else result
reg2_in  input  32  store data
mem_req  output  1  access request, held until mem_ready
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  ADDR_W  word address
mem_wdata  output  32  store data
mem_rdata  input  32  load data, valid with mem_ready
mem_ready  input  1  access complete (single-cycle pulse)
freeze  output  1  hold PC, IF/ID, ID/EX and EXE/MEM registers
mem_err  output  1  one-cycle pulse on timeout abort
WB_en_out  output  1  MEM/WB write-back enable
MEM_R_en_out  output  1  MEM/WB: value comes from memory
dest_out  output  5  MEM/WB destination
PC_out  output  32  MEM/WB PC
ALU_result_out  output  32  MEM/WB ALU result
mem_data_out  output  32  MEM/WB loaded data

Behaviour:
- Reset: all outputs 0, FSM = IDLE, timeout counter = 0. Reset mid-access drops mem_req on the next edge; the in-flight access is abandoned and a late mem_ready is ignored.
- Access request: acc = MEM_Signal_in != 0. If MEM_Signal_in = 2'b11, the access is a read (mem_we = 0).
- FSM IDLE:
  - If acc: latch mem_addr = ALU_result_in[ADDR_W+1:2], mem_wdata = reg2_in, mem_we = MEM_Signal_in == 2'b01. Go to WAIT; mem_req = 1 from the next cycle.
  - If not acc: stay in IDLE.
- FSM WAIT:
  - mem_req, mem_we, mem_addr and mem_wdata are held stable.
  - Counter increments each cycle.
  - On mem_ready: go to IDLE, counter cleared.
  - If TIMEOUT != 0 and counter reaches TIMEOUT-1 without mem_ready: go to IDLE, pulse mem_err, loaded data forced to 0.
- mem_req is registered; it is 1 exactly while state = WAIT.
- freeze (combinational): acc && !(state == WAIT && (mem_ready || timeout_hit)). A non-memory instruction never freezes.
- MEM/WB register, updated every edge:
  - While freeze = 1: load a bubble (WB_en_out = 0, MEM_R_en_out = 0, other fields 0).
  - Otherwise: load WB_en_in, MEM_Signal_in[1], dest_in, PC_in, ALU_result_in, and mem_data = mem_rdata on read completion, else 0.
- Latency:
  - Non-memory op: 1 cycle (plain register).
  - Memory op: 1 + N cycles, where N = WAIT cycles up to and including mem_ready; minimum 2.
- mem_ready while IDLE is ignored.
- Back-to-back accesses: the completion edge advances EXE/MEM. The next access is seen in IDLE on the following cycle, giving one idle cycle between requests.
- Stores: WB_en_out is passed through as given (normally 0). mem_data_out = 0.

Decomposition:
- Shared package:
  - MEM_R_BIT = 1, MEM_W_BIT = 0
  - FSM state encoding IDLE = 1'b0, WAIT = 1'b1
  - Width constants REG_ADDR_W = 5, DATA_W = 32
- One natural sub-module: MemWbReg, the MEM/WB pipeline register with bubble-on-freeze, mirroring the existing EXE/MEM register structure.

Test Plan:
1. Reset: assert rst for 2 cycles during WAIT with mem_req = 1 -> next cycle mem_req = 0, all outputs 0, freeze = 0, later mem_ready ignored.
2. ALU passthrough: MEM_Signal_in = 0, WB_en_in = 1, dest_in = 5, ALU_result_in = 0x2A -> next edge WB_en_out = 1, dest_out = 5, ALU_result_out = 0x2A, freeze never high.
3. Load: MEM_Signal_in = 2'b10, ALU_result_in = 0x40, memory ready 3 cycles after req, mem_rdata = 0xDEADBEEF -> mem_addr = 0x10, mem_we = 0, freeze high 3 cycles. MEM/WB shows a bubble each frozen edge, then MEM_R_en_out = 1, mem_data_out = 0xDEADBEEF.
4. Store: MEM_Signal_in = 2'b01, ALU_result_in = 0x8, reg2_in = 0x1234, immediate ready -> mem_we = 1, mem_addr = 2, mem_wdata = 0x1234, freeze high 1 cycle, total latency 2.
5. Timeout: TIMEOUT = 4, load, mem_ready never asserts -> mem_req high 4 cycles, mem_err pulses once, mem_data_out = 0, pipeline resumes.
6. Back-to-back: load then store, each ready after 1 cycle -> two distinct req phases separated by one idle cycle, correct addresses and data, no lost or duplicated MEM/WB entries.
